// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS-16 instruction-memory loader.
package mips_pkg;
  localparam int INST_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } ldr_state_t;
endpackage

// File: rtl/ldr_byte_pack.sv
// Assembles two stream bytes into one instruction word; the word register is
// also the instruction-memory write data, so it holds its value between loads.
module ldr_byte_pack
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              sel_hi,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [INST_W-1:0] word
);
  logic [INST_W-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (load_en) begin
      if (sel_hi) word_d[INST_W-1 -: BYTE_W] = byte_in;
      else        word_d[BYTE_W-1:0]         = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign word = word_q;
endmodule

// File: rtl/imem_loader.sv
// Streams a big-endian program image (count, then words) into instruction memory
// and holds the core in reset until done. LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int          CNT_W = ADDR_W + 1;
  localparam logic [15:0] MAX_N = 16'(1 << ADDR_W);

  ldr_state_t        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              pack_en, pack_hi;
  logic              xfer;
  logic [15:0]       n_full;
  logic [15:0]       cnt_inc;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  assign xfer    = in_valid & in_ready_q;
  assign n_full  = {n_q[15:8], in_data};
  assign cnt_inc = 16'(cnt_q) + 16'd1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    pack_en = 1'b0;
    pack_hi = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (xfer && state_q != S_CHK) csum_d = csum_q ^ in_data;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          n_d[15:8] = in_data;
          state_d   = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d    = n_full;
          cnt_d  = '0;
          addr_d = '0;
          if (n_full == 16'd0)     state_d = S_DONE;
          else if (n_full > MAX_N) state_d = S_ERR;
          else                     state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          pack_en = 1'b1;
          pack_hi = 1'b1;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          pack_en = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d  = cnt_q + 1'b1;
        addr_d = addr_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        state_d = (cnt_inc == n_q) ? S_CHK : S_DATA_HI;
`else
        state_d = (cnt_inc == n_q) ? S_DONE : S_DATA_HI;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                 (state_d == S_CHK);
    imem_we_d  = (state_d == S_WRITE);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_rst_d  = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      imem_we_q  <= imem_we_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  ldr_byte_pack u_pack (
    .clk     (clk),
    .rst     (rst),
    .load_en (pack_en),
    .sel_hi  (pack_hi),
    .byte_in (in_data),
    .word    (imem_wdata)
  );

  assign in_ready  = in_ready_q;
  assign imem_we   = imem_we_q;
  assign imem_addr = addr_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the 16-bit single-cycle MIPS core's instruction fetch: streams a program image into instruction memory, then releases the core.
- Receives a byte stream (valid/ready), assembles 16-bit instruction words and drives the instruction-memory write port.
- Holds the core in reset (cpu_rst) until the image is fully written.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  pulse; begins a load
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte this cycle
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  16  instruction word
- cpu_rst  output  1  reset to MIPS core; high while not successfully loaded
- busy  output  1  load in progress
- done  output  1  image loaded successfully
- err  output  1  load aborted

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0; state IDLE.
- Byte transfer occurs on a rising edge where in_valid & in_ready.
- Stream format, big-endian:
  - 2-byte word count N (high byte first).
  - N words, each high byte then low byte.
- States:
  - IDLE: in_ready=0. start -> LEN_HI; busy=1, cpu_rst=1, done=0, err=0.
  - LEN_HI: in_ready=1. Byte -> N[15:8]; -> LEN_LO.
  - LEN_LO: in_ready=1. Byte -> N[7:0]; word counter and imem_addr cleared.
    - N=0 -> DONE.
    - N > 2^ADDR_W -> ERR.
    - Otherwise -> DATA_HI.
  - DATA_HI: in_ready=1. Byte -> imem_wdata[15:8]; -> DATA_LO.
  - DATA_LO: in_ready=1. Byte -> imem_wdata[7:0]; -> WRITE.
  - WRITE: in_ready=0; imem_we=1 for exactly this one cycle at the current imem_addr. Next edge: counter+1, imem_addr+1.
    - If counter+1 == N -> DONE (CHK when LOADER_CHECKSUM_EN is defined).
    - Else -> DATA_HI.
  - DONE: busy=0, done=1, cpu_rst=0. start -> LEN_HI with done=0, cpu_rst=1.
  - ERR: busy=0, err=1, cpu_rst=1, in_ready=0. start -> LEN_HI with err cleared.
- start is ignored in LEN_HI through WRITE/CHK.
- in_valid low stalls any receive state indefinitely; no timeout.
- Throughput: 2 bytes per 3 cycles at best (one write bubble per word).
- Address arithmetic:
  - imem_addr is ADDR_W bits; counter is ADDR_W+1 bits, so N = 2^ADDR_W is legal.
  - With N = 2^ADDR_W, imem_addr wraps to 0 after the final write (harmless; no further write).
- imem_wdata holds its last value outside WRITE.
- rst mid-load: immediate return to reset values; partially written memory is not cleared.
- cpu_rst is a registered output; it falls on the same edge that enters DONE.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - A running 8-bit XOR is taken over all header and data bytes.
  - After the last WRITE the FSM enters CHK (in_ready=1) and accepts one checksum byte.
  - Match -> DONE; mismatch -> ERR.
- Undefined: no CHK state; no trailing byte; the stream ends after the last data byte.

Decomposition:
- Shared package mips_pkg:
  - state enum type ldr_state_t.
  - constants INST_W=16, BYTE_W=8.
- One natural sub-module: ldr_byte_pack, a 2-byte to 16-bit word assembler with hi/lo select and load enable.
- FSM, counter and checksum stay in imem_loader.

Test Plan:
- ADDR_W=8, start, stream 00 03 12 34 AB CD 00 01 with continuous valid -> writes 0x1234@0, 0xABCD@1, 0x0001@2, each imem_we exactly one cycle; done=1, cpu_rst=0 after third write.
- Same stream with in_valid deasserted for 5 cycles between every byte -> identical writes and no extra imem_we.
- N=0 (stream 00 00) -> DONE with no imem_we; N=0x0101 with ADDR_W=8 -> ERR, err=1, cpu_rst=1, in_ready=0.
- rst asserted after 3 words of a 10-word load -> all outputs at reset values next cycle; new start plus full stream -> done=1.
- start pulsed in DATA_LO -> ignored, load completes normally; start in DONE -> cpu_rst=1, done=0, reload succeeds.
- LOADER_CHECKSUM_EN: stream 00 01 12 34 then checksum 0x27 -> done=1; checksum 0x28 -> err=1, cpu_rst=1.
